// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate defaults, bit-timing derivation and the receiver state encoding.
// Used by both the receive and transmit peripherals.
package uart_pkg;

   localparam int unsigned DEF_CLK_FREQ_HZ  = 32'd12000000;
   localparam int unsigned DEF_BAUD         = 32'd9600;
   localparam int unsigned DEF_CLKS_PER_BIT = DEF_CLK_FREQ_HZ / DEF_BAUD;
   localparam int unsigned DEF_HALF_BIT     = DEF_CLKS_PER_BIT / 32'd2;

   // Bit-timing counter must hold CLKS_PER_BIT-1 (1249 at 12 MHz / 9600 baud).
   localparam int unsigned CNT_W = 32'd11;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   // Even-parity bit for a data byte: makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a falling-edge detector.
// All flops reset to 1 so that an idle-high line never produces a spurious edge.
module uart_rx_sync (
   input  logic clk_12mhz,
   input  logic reset,
   input  logic uart_rx,
   output logic rx_s,
   output logic rx_fall_s
);

   logic sync1_r;
   logic sync2_r;
   logic line_prev_r;

   // Synchroniser chain and previous-value flop for edge detection.
   always_ff @(posedge clk_12mhz or negedge reset) begin
      if (!reset) begin
         sync1_r     <= 1'b1;
         sync2_r     <= 1'b1;
         line_prev_r <= 1'b1;
      end else begin
         sync1_r     <= uart_rx;
         sync2_r     <= sync1_r;
         line_prev_r <= sync2_r;
      end
   end

   assign rx_s      = sync2_r;
   assign rx_fall_s = line_prev_r & ~sync2_r;

endmodule

// File: rtl/uart_rx_peripheral.sv
// UART receiver, 8N1 by default, with a valid/ready byte output plus frame-error and overrun flags.
// Define UART_RX_PARITY_EN for 8E1 framing and the rx_parity_err output.
module uart_rx_peripheral
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
   parameter int unsigned BAUD        = DEF_BAUD
) (
   input  logic       clk_12mhz,
   input  logic       reset,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_frame_err,
   output logic       rx_overrun,
   output logic       rx_busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic       rx_parity_err
`endif
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 32'd2;
   localparam cnt_t        HALF_LAST    = cnt_t'(HALF_BIT - 32'd1);
   localparam cnt_t        BIT_LAST     = cnt_t'(CLKS_PER_BIT - 32'd1);

   logic      rx_s;
   logic      rx_fall_s;

   rx_state_t state_r;
   rx_state_t next_state_s;
   cnt_t      clk_cnt_r;
   cnt_t      clk_cnt_next_s;
   logic [2:0] bit_idx_r;
   logic [2:0] bit_idx_next_s;
   logic [7:0] shift_r;
   logic [7:0] shift_next_s;
   logic      half_hit_s;
   logic      bit_hit_s;
   logic      stop_sample_s;
   logic      frame_err_s;
   logic      commit_s;
   logic      handshake_s;
`ifdef UART_RX_PARITY_EN
   logic      parity_bit_r;
   logic      parity_bit_next_s;
   logic      parity_err_s;
`endif

   uart_rx_sync u_sync (
      .clk_12mhz (clk_12mhz),
      .reset     (reset),
      .uart_rx   (uart_rx),
      .rx_s      (rx_s),
      .rx_fall_s (rx_fall_s)
   );

   assign half_hit_s = (clk_cnt_r == HALF_LAST);
   assign bit_hit_s  = (clk_cnt_r == BIT_LAST);

   // Receiver state, bit timing and shift register.
   always_ff @(posedge clk_12mhz or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         clk_cnt_r    <= '0;
         bit_idx_r    <= 3'd0;
         shift_r      <= 8'h00;
`ifdef UART_RX_PARITY_EN
         parity_bit_r <= 1'b0;
`endif
      end else begin
         state_r      <= next_state_s;
         clk_cnt_r    <= clk_cnt_next_s;
         bit_idx_r    <= bit_idx_next_s;
         shift_r      <= shift_next_s;
`ifdef UART_RX_PARITY_EN
         parity_bit_r <= parity_bit_next_s;
`endif
      end
   end

   // Next-state logic; the bit counter restarts on every state entry and after each data sample.
   always_comb begin
      next_state_s      = state_r;
      clk_cnt_next_s    = clk_cnt_r + cnt_t'(1);
      bit_idx_next_s    = bit_idx_r;
      shift_next_s      = shift_r;
      stop_sample_s     = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_next_s = parity_bit_r;
`endif
      case (state_r)
         IDLE: begin
            // Only a high-to-low transition starts a frame, so a held-low break never re-arms.
            if (rx_fall_s) begin
               next_state_s   = START;
               clk_cnt_next_s = '0;
            end else begin
               next_state_s   = IDLE;
            end
         end
         START: begin
            if (half_hit_s) begin
               clk_cnt_next_s = '0;
               bit_idx_next_s = 3'd0;
               if (!rx_s) begin
                  next_state_s = DATA;
               end else begin
                  next_state_s = IDLE;
               end
            end else begin
               next_state_s = START;
            end
         end
         DATA: begin
            if (bit_hit_s) begin
               clk_cnt_next_s = '0;
               shift_next_s   = {rx_s, shift_r[7:1]};
               if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  next_state_s = PARITY;
`else
                  next_state_s = STOP;
`endif
               end else begin
                  bit_idx_next_s = bit_idx_r + 3'd1;
               end
            end else begin
               next_state_s = DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bit_hit_s) begin
               clk_cnt_next_s    = '0;
               parity_bit_next_s = rx_s;
               next_state_s      = STOP;
            end else begin
               next_state_s      = PARITY;
            end
         end
`endif
         STOP: begin
            if (bit_hit_s) begin
               clk_cnt_next_s = '0;
               stop_sample_s  = 1'b1;
               next_state_s   = IDLE;
            end else begin
               next_state_s   = STOP;
            end
         end
         default: begin
            next_state_s   = IDLE;
            clk_cnt_next_s = '0;
         end
      endcase
   end

   assign frame_err_s = stop_sample_s & ~rx_s;
   assign handshake_s = rx_valid & rx_ready;
`ifdef UART_RX_PARITY_EN
   assign parity_err_s = stop_sample_s & (parity_bit_r != even_parity(shift_r));
   assign commit_s     = stop_sample_s & rx_s & ~parity_err_s;
`else
   assign commit_s     = stop_sample_s & rx_s;
`endif

   // Output port: byte hand-off, overrun tracking and one-cycle error pulses.
   always_ff @(posedge clk_12mhz or negedge reset) begin
      if (!reset) begin
         rx_data       <= 8'h00;
         rx_valid      <= 1'b0;
         rx_overrun    <= 1'b0;
         rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
      end else begin
         rx_frame_err  <= frame_err_s;
`ifdef UART_RX_PARITY_EN
         rx_parity_err <= parity_err_s;
`endif
         if (commit_s && (!rx_valid || handshake_s)) begin
            rx_data    <= shift_r;
            rx_valid   <= 1'b1;
            rx_overrun <= 1'b0;
         end else if (commit_s) begin
            // Previous byte still pending: keep it and drop the new one.
            rx_overrun <= 1'b1;
         end else if (handshake_s) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
         end else begin
            rx_valid   <= rx_valid;
            rx_overrun <= rx_overrun;
         end
      end
   end

   assign rx_busy = (state_r != IDLE);

endmodule

// File: tb/tb_uart_rx_peripheral.sv
// Directed testbench for uart_rx_peripheral: valid/ready hand-off, latency, overrun, framing errors,
// break handling, glitch rejection and mid-frame reset (parity cases when UART_RX_PARITY_EN is set).
module tb_uart_rx_peripheral;

   localparam int BIT_CLKS = 1250;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 2 + 625 + 10 * 1250 + 1;
`else
   localparam int LAT = 2 + 625 + 9 * 1250 + 1;
`endif

   logic       clk_12mhz = 1'b0;
   logic       reset;
   logic       uart_rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_busy;
`ifdef UART_RX_PARITY_EN
   logic       rx_parity_err;
   logic       par_flip = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int frame_start_cyc = 0;
   int valid_cnt = 0;
   int ferr_cnt  = 0;
   int perr_cnt  = 0;
   int valid_rise_cyc = 0;
   logic valid_prev = 1'b0;
   int v0;
   int f0;
   int p0;

   uart_rx_peripheral dut (
      .clk_12mhz    (clk_12mhz),
      .reset        (reset),
      .uart_rx      (uart_rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun),
      .rx_busy      (rx_busy)
`ifdef UART_RX_PARITY_EN
      ,
      .rx_parity_err(rx_parity_err)
`endif
   );

   always #5 clk_12mhz = ~clk_12mhz;

   always @(posedge clk_12mhz) cyc <= cyc + 1;

   // Pulse monitor on the falling edge, away from where the DUT updates.
   always @(negedge clk_12mhz) begin
      if (rx_valid) valid_cnt <= valid_cnt + 1;
      if (rx_valid && !valid_prev) valid_rise_cyc <= cyc;
      valid_prev <= rx_valid;
      if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
      if (rx_parity_err) perr_cnt <= perr_cnt + 1;
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk_12mhz);
      #1;
   endtask

   // Drives one frame; the line is left at the stop-bit level.
   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      frame_start_cyc = cyc;
      uart_rx = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         wait_clks(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      uart_rx = (^d) ^ par_flip;
      wait_clks(BIT_CLKS);
`endif
      uart_rx = stop_b;
      wait_clks(BIT_CLKS);
   endtask

   initial begin
      reset    = 1'b0;
      uart_rx  = 1'b1;
      rx_ready = 1'b1;
      wait_clks(5);
      check("rst_data",    {24'd0, rx_data}, 32'h00);
      check("rst_valid",   {31'd0, rx_valid}, 32'd0);
      check("rst_ferr",    {31'd0, rx_frame_err}, 32'd0);
      check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
      check("rst_busy",    {31'd0, rx_busy}, 32'd0);
      reset = 1'b1;
      wait_clks(20);

      // Basic frame with consumer ready: one-cycle valid pulse at the expected latency.
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(8'h77, 1'b1);
      wait_clks(10);
      check("t1_latency", valid_rise_cyc - frame_start_cyc, LAT);
      check("t1_pulse",   valid_cnt - v0, 32'd1);
      check("t1_data",    {24'd0, rx_data}, 32'h77);
      check("t1_ferr",    ferr_cnt - f0, 32'd0);
      check("t1_overrun", {31'd0, rx_overrun}, 32'd0);

`ifdef UART_RX_PARITY_EN
      // Wrong parity bit: error pulse, byte discarded.
      v0 = valid_cnt; p0 = perr_cnt;
      par_flip = 1'b1;
      send_frame(8'h77 ^ 8'h01, 1'b1);
      par_flip = 1'b0;
      wait_clks(10);
      check("par_err_pulse", perr_cnt - p0, 32'd1);
      check("par_no_valid",  valid_cnt - v0, 32'd0);
      check("par_data_kept", {24'd0, rx_data}, 32'h77);
`else
      // Consumer stalled across two back-to-back frames.
      rx_ready = 1'b0;
      send_frame(8'h41, 1'b1);
      wait_clks(2);
      check("ovr_first_valid", {31'd0, rx_valid}, 32'd1);
      check("ovr_first_flag",  {31'd0, rx_overrun}, 32'd0);
      send_frame(8'h42, 1'b1);
      wait_clks(10);
      check("ovr_data_kept", {24'd0, rx_data}, 32'h41);
      check("ovr_valid",     {31'd0, rx_valid}, 32'd1);
      check("ovr_flag",      {31'd0, rx_overrun}, 32'd1);
      rx_ready = 1'b1;
      wait_clks(1);
      check("ovr_hs_valid", {31'd0, rx_valid}, 32'd0);
      check("ovr_hs_flag",  {31'd0, rx_overrun}, 32'd0);
`endif

      // Stop bit low followed by a held-low break.
      v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      send_frame(8'h55, 1'b0);
      wait_clks(10);
      check("ferr_pulse",    ferr_cnt - f0, 32'd1);
      check("ferr_no_valid", valid_cnt - v0, 32'd0);
`ifdef UART_RX_PARITY_EN
      check("ferr_no_perr",  perr_cnt - p0, 32'd0);
      check("ferr_data",     {24'd0, rx_data}, 32'h77);
`else
      check("ferr_data",     {24'd0, rx_data}, 32'h41);
`endif
      wait_clks(2000);
      check("break_idle", {31'd0, rx_busy}, 32'd0);
      uart_rx = 1'b1;
      wait_clks(50);
      uart_rx = 1'b0;
      wait_clks(5);
      check("break_rearm", {31'd0, rx_busy}, 32'd1);
      uart_rx = 1'b1;
      wait_clks(700);
      check("break_reject", {31'd0, rx_busy}, 32'd0);

      // 300-clock low glitch: START held until the half-bit sample, then dropped.
      v0 = valid_cnt; f0 = ferr_cnt;
      uart_rx = 1'b0;
      wait_clks(100);
      check("glitch_start", {31'd0, rx_busy}, 32'd1);
      wait_clks(200);
      uart_rx = 1'b1;
      wait_clks(200);
      check("glitch_hold", {31'd0, rx_busy}, 32'd1);
      wait_clks(300);
      check("glitch_idle",  {31'd0, rx_busy}, 32'd0);
      check("glitch_valid", valid_cnt - v0, 32'd0);
      check("glitch_ferr",  ferr_cnt - f0, 32'd0);

      // Reset during data bit 4, then a clean frame.
      uart_rx = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         uart_rx = i[0];
         wait_clks(BIT_CLKS);
      end
      uart_rx = 1'b1;
      wait_clks(600);
      reset = 1'b0;
      wait_clks(3);
      check("mrst_busy",  {31'd0, rx_busy}, 32'd0);
      check("mrst_valid", {31'd0, rx_valid}, 32'd0);
      check("mrst_data",  {24'd0, rx_data}, 32'h00);
      reset = 1'b1;
      wait_clks(20);
      v0 = valid_cnt;
      send_frame(8'hA5, 1'b1);
      wait_clks(10);
      check("mrst_only_one", valid_cnt - v0, 32'd1);
      check("mrst_new_data", {24'd0, rx_data}, 32'hA5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
